// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types for the LC-3 SRAM path.
// Sequencer states, port id and default strobe length.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  typedef logic port_id_t;

  localparam int WAIT_DEF = 2;

endpackage

// File: rtl/arb2_rr.sv
// arb2_rr: two-way round-robin pick.
// Purely combinational; last_grant register lives in the parent.
import lc3_mem_pkg::*;

module arb2_rr (
  input  logic     Req0,
  input  logic     Req1,
  input  port_id_t last_grant,
  output port_id_t grant,
  output logic     valid
);

  // On a tie the port not served last wins
  always_comb begin
    valid = Req0 | Req1;
    grant = 1'b0;
    if (Req0 && Req1)
      grant = ~last_grant;
    else
      grant = Req1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port async SRAM arbiter and strobe sequencer.
// Latches the winner, runs a fixed strobe window, pulses Ack.
import lc3_mem_pkg::*;

module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = WAIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] Rdata,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_Dout,
  output logic              Mem_Dout_en,
  input  logic [DATA_W-1:0] Mem_Din,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t     state;
  port_id_t   gid;
  port_id_t   last_grant;
  port_id_t   gnt;
  logic       gnt_vld;
  logic       we_q;
  logic [3:0] cnt;

  arb2_rr u_arb (
    .Req0       (Req0),
    .Req1       (Req1),
    .last_grant (last_grant),
    .grant      (gnt),
    .valid      (gnt_vld)
  );

  // Sequencer: IDLE latches winner, ACCESS strobes, ACK pulses
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      gid         <= 1'b0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
      cnt         <= '0;
      Ack0        <= 1'b0;
      Ack1        <= 1'b0;
      Rdata       <= '0;
      Mem_ADDR    <= '0;
      Mem_Dout    <= '0;
      Mem_Dout_en <= 1'b0;
      Mem_CE      <= 1'b1;
      Mem_UB      <= 1'b1;
      Mem_LB      <= 1'b1;
      Mem_OE      <= 1'b1;
      Mem_WE      <= 1'b1;
    end else begin
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            gid         <= gnt;
            Mem_ADDR    <= gnt ? Addr1 : Addr0;
            Mem_Dout    <= gnt ? Wdata1 : Wdata0;
            we_q        <= gnt ? We1 : We0;
            cnt         <= '0;
            Mem_CE      <= 1'b0;
            Mem_UB      <= 1'b0;
            Mem_LB      <= 1'b0;
            Mem_OE      <= gnt ? We1 : We0;
            Mem_WE      <= gnt ? ~We1 : ~We0;
            Mem_Dout_en <= gnt ? We1 : We0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            Mem_CE      <= 1'b1;
            Mem_UB      <= 1'b1;
            Mem_LB      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            Mem_Dout_en <= 1'b0;
            if (!we_q)
              Rdata <= Mem_Din;
            if (gid)
              Ack1 <= 1'b1;
            else
              Ack0 <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ACK: begin
          last_grant <= gid;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port SRAM access arbiter and cycle sequencer for the simplified LC-3 system. Port 0 carries CPU memory transactions from the MAR/MDR path, including instruction fetch and LDR/STR. Port 1 serves the board-side program loader and debug reader. The block grants the single asynchronous SRAM to one port at a time using round-robin, runs a fixed-length read or write strobe sequence, and drives all active-low SRAM controls.

## Interface
Parameters:
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 2, strobe cycles per access (legal range 1..15)

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset_n  in  1  one clock; reset is asynchronous and active-low
- Req0, Req1  in  1 each  access request, held until matching Ack
- We0, We1  in  1 each  1 = write, 0 = read; valid while Req high
- Addr0, Addr1  in  ADDR_W each  access address, stable while Req high
- Wdata0, Wdata1  in  DATA_W each  write data, stable while Req high
- Ack0, Ack1  out  1 each  single-cycle completion pulse
- Rdata  out  DATA_W  registered read data; valid in the Ack cycle and held until the next read completes
- Mem_ADDR  out  ADDR_W  address to SRAM
- Mem_Dout  out  DATA_W  data to SRAM pad tristate
- Mem_Dout_en  out  1  1 = drive pads with Mem_Dout
- Mem_Din  in  DATA_W  data from SRAM pads
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM controls

## Operation
- States: IDLE, ACCESS, ACK.
- **IDLE.** Strobes inactive.
  - If any Req is high, latch the winner id, its address, its data and its We.
  - Clear the cycle counter and go to ACCESS.
- **Arbitration.**
  - Only one Req high: that port wins.
  - Both Req high: the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- **ACCESS.**
  - Mem_CE, Mem_UB and Mem_LB are low.
  - Read: Mem_OE low, Mem_WE high, Mem_Dout_en 0.
  - Write: Mem_WE low, Mem_OE high, Mem_Dout_en 1.
  - The counter increments each cycle.
  - When the counter reaches WAIT_CYCLES-1, go to ACK. On a read, Rdata <= Mem_Din on that same edge.
- **ACK.**
  - Ack of the granted port is 1 for exactly one cycle. All strobes are inactive; this cycle is the bus turnaround.
  - `last_grant` is updated and the next state is IDLE.
- Mem_ADDR and Mem_Dout come from the latched registers, so they stay stable through ACCESS even if the requester changes its inputs.
- The requester drops Req by the edge ending its Ack cycle. If Req is still high in the following IDLE cycle, it is a new request.
- A Req that falls before its Ack is a protocol violation. The access completes anyway and Ack still pulses.
- The counter is 4 bits wide and is compared only against WAIT_CYCLES-1; it never wraps within an access.

## Timing
- Reset values:
  - State IDLE; Ack0 = Ack1 = 0; Rdata = 0; Mem_ADDR = 0; Mem_Dout = 0.
  - Mem_Dout_en = 0; Mem_OE = Mem_WE = 1; Mem_CE = Mem_UB = Mem_LB = 1.
  - `last_grant` = 1.
- Latency: Req sampled at edge E0 leads to strobes active for cycles E0..E0+WAIT_CYCLES-1. Ack is high in the cycle starting at edge E0+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles under continuous contention.
- Reset asserted mid-access: all outputs take their reset values immediately and asynchronously. The access is aborted, no Ack is issued, and a write in progress may be corrupted.
- Mem_Dout_en and Mem_WE never change in the same cycle that Mem_OE goes low.

## Structure
- Package `lc3_mem_pkg`:
  - state enum (IDLE, ACCESS, ACK);
  - `port_id_t` (1 bit);
  - default WAIT_CYCLES constant.
- Sub-module `arb2_rr`: inputs Req0, Req1 and last_grant; outputs the grant id and a valid flag; purely combinational. The `last_grant` register stays in the parent.

## Test plan
- Reset, then Req0 read at Addr0 = 0x00010 with the SRAM model returning 0x1234 → Mem_OE low for 2 cycles; Ack0 in the 3rd cycle after the sampling edge; Rdata = 0x1234.
- Req1 write, Addr1 = 0x00042, Wdata1 = 0xBEEF → Mem_WE low for 2 cycles with Mem_Dout_en = 1 and Mem_OE high; a later read of 0x00042 returns 0xBEEF.
- Req0 and Req1 both high from reset, both reads → order is 0, 1, 0, 1; Acks spaced 4 cycles apart; each Rdata matches its own port's address.
- Change Addr0 during ACCESS → Mem_ADDR keeps the originally latched value through ACCESS and the read data is correct for that address.
- Assert Reset_n low during the 1st ACCESS cycle of a write → all strobes high and Mem_Dout_en = 0 immediately; no Ack; after release, IDLE with `last_grant` = 1.
- Build with WAIT_CYCLES = 1 and issue back-to-back reads on port 0 → an Ack every 3 cycles; no cycle has Mem_OE and Mem_WE both low.
